// File: rtl/mc_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath it steers.
// The FSM side (master) reads instruction fields and memory status and drives every enable/select.
interface mc_main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ByteLd;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, ByteLd, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, ByteLd, State
  );
endinterface

// File: rtl/mc_main_fsm.sv
// Multicycle main control FSM: sequences one instruction through fetch, decode,
// execute/memory and writeback, stalling on memory wait states.
module mc_main_fsm (
  input  logic           clk,
  input  logic           reset,
  mc_main_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ByteLd    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 through the ALU; IR and PC only commit once the fetch completes
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.NextPC    = bus.MemReady;
        state_d       = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcB = 2'b01;
        state_d     = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        bus.ByteLd = bus.Funct[2];
        state_d    = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
        bus.ByteLd    = bus.Funct[2];
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
        state_d    = bus.MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTER: begin
        bus.ALUOp = 1'b1;
        state_d   = (bus.Funct[4:1] == CMD_CMP) ? S_FETCH : S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
        state_d     = (bus.Funct[4:1] == CMD_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegW = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
        state_d       = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.State = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Randomized bench for mc_main_fsm: an instruction-level model expands each instruction
// and its wait pattern into the expected per-cycle state/control sequence.
module tb_mc_main_fsm;

  logic clk;
  logic reset;
  mc_main_fsm_if bus();

  mc_main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       br;
    logic       bld;
  } ctl_t;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  int checks_total = 0;
  int checks_pass  = 0;
  int instr_no     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_pass++;
    else $display("FAIL instr%0d %s got=%0h exp=%0h", instr_no, tag, got, exp);
  endtask

  // Control values the datapath needs in each step of the instruction.
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] f, input logic mr);
    ctl_t c;
    c = '0;
    case (st)
      0: begin c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; c.irw = mr; c.npc = mr; end
      1: begin c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; end
      2: begin c.srcb = 2'b01; end
      3: begin c.adr = 1; c.bld = f[2]; end
      4: begin c.res = 2'b01; c.regw = 1; c.bld = f[2]; end
      5: begin c.adr = 1; c.memw = 1; end
      6: begin c.aluop = 1; end
      7: begin c.srcb = 2'b01; c.aluop = 1; end
      8: begin c.regw = 1; end
      9: begin c.srcb = 2'b01; c.res = 2'b10; c.br = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check_outputs(input int st, input logic [5:0] f, input logic mr);
    ctl_t e;
    e = exp_ctl(st, f, mr);
    check_eq("State",     {28'd0, bus.State},     st);
    check_eq("IRWrite",   {31'd0, bus.IRWrite},   {31'd0, e.irw});
    check_eq("NextPC",    {31'd0, bus.NextPC},    {31'd0, e.npc});
    check_eq("AdrSrc",    {31'd0, bus.AdrSrc},    {31'd0, e.adr});
    check_eq("ALUSrcA",   {31'd0, bus.ALUSrcA},   {31'd0, e.srca});
    check_eq("ALUSrcB",   {30'd0, bus.ALUSrcB},   {30'd0, e.srcb});
    check_eq("ResultSrc", {30'd0, bus.ResultSrc}, {30'd0, e.res});
    check_eq("ALUOp",     {31'd0, bus.ALUOp},     {31'd0, e.aluop});
    check_eq("RegW",      {31'd0, bus.RegW},      {31'd0, e.regw});
    check_eq("MemW",      {31'd0, bus.MemW},      {31'd0, e.memw});
    check_eq("Branch",    {31'd0, bus.Branch},    {31'd0, e.br});
    check_eq("ByteLd",    {31'd0, bus.ByteLd},    {31'd0, e.bld});
  endtask

  // Expand one instruction plus its wait counts into the cycle-by-cycle step list.
  task automatic build_steps(input logic [1:0] op, input logic [5:0] f, input int wf, input int wm,
                             output step_t q[$]);
    step_t s;
    q = {};
    for (int i = 0; i < wf; i++) begin s.st = 0; s.mr = 0; q.push_back(s); end
    s.st = 0; s.mr = 1; q.push_back(s);
    s.st = 1; s.mr = 1'($urandom); q.push_back(s);
    if (op == 2'b00) begin
      s.st = f[5] ? 7 : 6; s.mr = 1'($urandom); q.push_back(s);
      if (f[4:1] != 4'b1010) begin s.st = 8; s.mr = 1'($urandom); q.push_back(s); end
    end else if (op == 2'b01) begin
      s.st = 2; s.mr = 1'($urandom); q.push_back(s);
      for (int i = 0; i < wm; i++) begin s.st = f[0] ? 3 : 5; s.mr = 0; q.push_back(s); end
      s.st = f[0] ? 3 : 5; s.mr = 1; q.push_back(s);
      if (f[0]) begin s.st = 4; s.mr = 1'($urandom); q.push_back(s); end
    end else if (op == 2'b10) begin
      s.st = 9; s.mr = 1'($urandom); q.push_back(s);
    end
  endtask

  // abort_st >= 0: pulse reset in the first cycle spent in that state.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input int wf, input int wm,
                           input int abort_st);
    step_t q[$];
    int    regw_seen;
    int    memw_seen;
    int    regw_exp;
    int    memw_exp;
    instr_no++;
    build_steps(op, f, wf, wm, q);
    regw_seen = 0;
    memw_seen = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.Op    = op;
        bus.Funct = f;
      end
      bus.MemReady = q[i].mr;
      #1;
      check_outputs(q[i].st, f, q[i].mr);
      if (bus.RegW === 1'b1) regw_seen++;
      if (bus.MemW === 1'b1) memw_seen++;
      if (q[i].st == abort_st) begin
        bus.MemReady = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("abort_State", {28'd0, bus.State}, 32'd0);
        check_eq("abort_RegW",  {31'd0, bus.RegW},  32'd0);
        check_eq("abort_MemW",  {31'd0, bus.MemW},  32'd0);
        check_eq("abort_ALUSrcB", {30'd0, bus.ALUSrcB}, 32'd2);
        @(posedge clk);
        #2 reset = 1'b0;
        $display("instr%0d op=%0d funct=%b wf=%0d wm=%0d aborted in state %0d",
                 instr_no, op, f, wf, wm, abort_st);
        return;
      end
    end
    regw_exp = ((op == 2'b00 && f[4:1] != 4'b1010) || (op == 2'b01 && f[0])) ? 1 : 0;
    memw_exp = (op == 2'b01 && !f[0]) ? wm + 1 : 0;
    check_eq("regw_pulses", regw_seen, regw_exp);
    check_eq("memw_cycles", memw_seen, memw_exp);
    $display("instr%0d op=%0d funct=%b wf=%0d wm=%0d cycles=%0d", instr_no, op, f, wf, wm, q.size());
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    reset        = 1'b1;
    bus.Op       = 2'b00;
    bus.Funct    = 6'd0;
    bus.MemReady = 1'b0;
    #3;
    check_outputs(0, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs(0, 6'd0, 1'b0);
    #1 reset = 1'b0;

    run_instr(2'b00, 6'b001000, 0, 0, -1);  // ADD register
    run_instr(2'b01, 6'b011101, 0, 2, -1);  // LDRB
    run_instr(2'b01, 6'b011000, 1, 0, -1);  // STR
    run_instr(2'b00, 6'b110101, 0, 0, -1);  // CMP immediate
    run_instr(2'b10, 6'b000000, 0, 0, -1);  // B
    run_instr(2'b11, 6'b101010, 0, 0, -1);  // undefined
    run_instr(2'b00, 6'b001000, 0, 0, 8);   // ADD aborted in ALUWB
    run_instr(2'b00, 6'b001000, 0, 0, -1);
    run_instr(2'b01, 6'b011000, 0, 1, 5);   // STR aborted in MEMWR
    run_instr(2'b01, 6'b011001, 2, 1, -1);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      f  = 6'($urandom);
      if ($urandom_range(0, 3) == 0) f[4:1] = 4'b1010;
      run_instr(op, f, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
